// File: rtl/im_loader.sv
// im_loader: packs a byte stream MSB-first into 32-bit words and writes them into instruction memory
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [11:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam logic [11:0] BASE_WA = BASE_ADDR[13:2];
  state_t state, state_nx;
  logic [1:0]  byte_cnt;
  logic [12:0] word_cnt, total;
  logic [31:0] word;
  logic        accept, hs, last, bad;
  assign accept   = start & (state == IDLE | state == DONE);
  assign hs       = byte_valid & byte_ready;
  assign last     = word_cnt + 13'd1 == total;
  assign bad      = 32'(num_words) > MAX_WORDS;
  assign im_wdata = word;
  // next-state and handshake/status decode
  always_comb begin
    state_nx   = state;
    byte_ready = state == RECV;
    im_we      = state == WRITE;
    busy       = state == RECV | state == WRITE;
    cpu_hold   = state == RECV | state == WRITE;
    done       = state == DONE;
    case (state)
      IDLE, DONE: if (start) state_nx = (num_words == 13'd0 || bad) ? DONE : RECV;
      RECV:       if (hs && byte_cnt == 2'd3) state_nx = WRITE;
      WRITE:      state_nx = last ? DONE : RECV;
      default:    state_nx = IDLE;
    endcase
  end
  // state, byte packing, address/count/checksum bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      word_cnt <= 13'd0;
      total    <= 13'd0;
      word     <= 32'd0;
      im_addr  <= BASE_WA;
      checksum <= 32'd0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        total    <= num_words;
        err      <= bad;
        checksum <= 32'd0;
        word_cnt <= 13'd0;
        byte_cnt <= 2'd0;
        im_addr  <= BASE_WA;
      end
      if (hs) begin
        word     <= {word[23:0], byte_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == WRITE) begin
        checksum <= checksum + word;
        word_cnt <= word_cnt + 13'd1;
        if (!last) im_addr <= im_addr + 12'd1;
      end
    end
  end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed self-checking bench for im_loader
module tb_im_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [12:0] num_words = 13'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, im_we, cpu_hold, busy, done, err;
  logic [11:0] im_addr;
  logic [31:0] im_wdata, checksum;
  int compared = 0;
  int mismatched = 0;
  int we_cnt = 0;
  int rdy_viol = 0;
  int hold_viol = 0;
  int base;
  logic [11:0] wa [0:63];
  logic [31:0] wd [0:63];

  im_loader dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // log every write and watch invariants on the edge that sees them
  always @(posedge clk) begin
    if (im_we) begin
      if (we_cnt < 64) begin
        wa[we_cnt] = im_addr;
        wd[we_cnt] = im_wdata;
      end
      we_cnt = we_cnt + 1;
      if (byte_ready) rdy_viol = rdy_viol + 1;
    end
    if (cpu_hold !== busy) hold_viol = hold_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hs_wait", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_start(input logic [12:0] n);
    start     = 1'b1;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(im_we), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_addr"}, 32'(im_addr), 32'h0C00);
    chk({tag, "_wdata"}, im_wdata, 32'd0);
    chk({tag, "_csum"}, checksum, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);
    // single word, back-to-back bytes
    base = we_cnt;
    do_start(13'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd1);
    send_word(32'h3408_0001, 0);
    chk("t1_we", 32'(im_we), 32'd1);
    chk("t1_ready_in_write", 32'(byte_ready), 32'd0);
    chk("t1_addr", 32'(im_addr), 32'h0C00);
    chk("t1_wdata", im_wdata, 32'h3408_0001);
    wait_done();
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_csum", checksum, 32'h3408_0001);
    chk("t1_nwrites", 32'(we_cnt - base), 32'd1);
    // three words with gaps between bytes
    base = we_cnt;
    do_start(13'd3);
    chk("t2_done_cleared", 32'(done), 32'd0);
    send_word(32'd1, 1);
    send_word(32'd2, 2);
    send_word(32'd3, 1);
    wait_done();
    chk("t2_nwrites", 32'(we_cnt - base), 32'd3);
    chk("t2_addr0", 32'(wa[base]), 32'h0C00);
    chk("t2_addr1", 32'(wa[base+1]), 32'h0C01);
    chk("t2_addr2", 32'(wa[base+2]), 32'h0C02);
    chk("t2_data2", wd[base+2], 32'd3);
    chk("t2_csum", checksum, 32'd6);
    chk("t2_hold_after", 32'(cpu_hold), 32'd0);
    // zero words and oversize request
    base = we_cnt;
    do_start(13'd0);
    chk("t3_zero_done", 32'(done), 32'd1);
    chk("t3_zero_err", 32'(err), 32'd0);
    chk("t3_zero_csum", checksum, 32'd0);
    do_start(13'd4097);
    chk("t3_big_done", 32'(done), 32'd1);
    chk("t3_big_err", 32'(err), 32'd1);
    chk("t3_big_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("t3_nwrites", 32'(we_cnt - base), 32'd0);
    // start during RECV is ignored
    base = we_cnt;
    do_start(13'd1);
    chk("t4_err_cleared", 32'(err), 32'd0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    do_start(13'd5);
    chk("t4_still_busy", 32'(busy), 32'd1);
    send_byte(8'hBE);
    send_byte(8'hEF);
    wait_done();
    chk("t4_nwrites", 32'(we_cnt - base), 32'd1);
    chk("t4_data", wd[base], 32'hDEAD_BEEF);
    chk("t4_csum", checksum, 32'hDEAD_BEEF);
    // reset in the middle of word 2
    base = we_cnt;
    do_start(13'd3);
    send_word(32'hAAAA_0001, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b0;
    #1;
    chk_reset_vals("t5");
    repeat (3) @(negedge clk);
    chk("t5_nwrites", 32'(we_cnt - base), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    base = we_cnt;
    do_start(13'd1);
    send_word(32'h1122_3344, 0);
    wait_done();
    chk("t5_reload_addr", 32'(wa[base]), 32'h0C00);
    chk("t5_reload_data", wd[base], 32'h1122_3344);
    // checksum wrap
    base = we_cnt;
    do_start(13'd2);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0002, 0);
    wait_done();
    chk("t6_csum", checksum, 32'h0000_0001);
    chk("t6_addr1", 32'(wa[base+1]), 32'h0C01);
    chk("t6_final_addr", 32'(im_addr), 32'h0C01);
    chk("rdy_during_write", 32'(rdy_viol), 32'd0);
    chk("hold_vs_busy", 32'(hold_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
